trace_monitor: RTL and testbench
================================

# trace_monitor

Synthesizable pipeline trace and halt monitor for the 5-stage Nios II core. It timestamps every fetched PC/instruction into a DEPTH-entry trace FIFO and keeps shadow copies of two architectural registers by snooping the write-back port. It detects the program-end condition: PC at or beyond a halt address while the watched loop register is zero. On halt it latches the result register for readout by a host, bench or UART bridge over a valid/ready port.

## Interface
- DATA_W, 32, width of PC, instruction and register data
- DEPTH, 16, trace FIFO entries; power of two, ≥2
- CNT_W, 32, cycle counter / timestamp width
- WATCH_REG, 4, register index whose zero value enables halt
- RESULT_REG, 5, register index latched as result on halt
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- en  in  1  capture enable; level
- clear  in  1  synchronous flush to IDLE
- pc_valid  in  1  pc/instr valid this cycle
- pc  in  DATA_W  fetch-stage PC
- instr  in  DATA_W  fetch-stage instruction
- wb_en  in  1  register write-back strobe
- wb_addr  in  5  write-back register index
- wb_data  in  DATA_W  write-back data
- halt_pc  in  DATA_W  halt address; unsigned compare
- rd_valid  out  1  trace record available
- rd_ready  in  1  host accepts record
- rd_stamp  out  CNT_W  record timestamp
- rd_pc  out  DATA_W  record PC
- rd_instr  out  DATA_W  record instruction
- cycles  out  CNT_W  RUN cycles elapsed
- overflow  out  1  sticky; a record was dropped
- drop_count  out  8  dropped records, saturating at 255
- busy  out  1  state is RUN or DRAIN
- done  out  1  state is DONE
- result  out  DATA_W  RESULT_REG value latched at halt

## Operation
- FSM has four states. Reset state is IDLE.
- IDLE → RUN when en=1. The transition cycle itself is not captured.
- RUN, en=1: cycles increments, saturating at 2^CNT_W−1. If pc_valid=1, push {cycles+1, pc, instr}; the stamp counts the current cycle.
- RUN, en=0: paused. No push, cycles held, and halt is not evaluated.
- RUN → DRAIN when en && pc_valid && pc ≥ halt_pc && shadow[WATCH_REG]==0.
  - The halting record is pushed.
  - The compare uses the registered shadow value, i.e. the value before any same-cycle write-back.
- DRAIN: no pushes and cycles held. Write-back snooping continues.
- DRAIN → DONE when FIFO is empty. On that transition, result ← shadow[RESULT_REG], taken after that cycle's write-back.
- DONE holds until rst or clear.
- clear (any state): FIFO flushed. cycles, overflow, drop_count, result and shadows are zeroed. Next state IDLE. clear has priority over every other event.
- Shadows: on wb_en, if wb_addr==WATCH_REG or RESULT_REG, the matching shadow ← wb_data. Writes to r0 are ignored (shadow index 0 is constant 0).
- FIFO pop occurs when rd_valid && rd_ready. rd_* are zero whenever rd_valid=0.
- FIFO full handling:
  - A push with no pop is dropped. overflow ← 1 and drop_count increments.
  - A push with a simultaneous pop is accepted, so occupancy stays DEPTH.
- Pointers are log2(DEPTH)+1 bits and wrap modulo 2·DEPTH. full = MSBs differ with the low bits equal.

## Timing
- Reset values: rd_valid 0, rd_stamp/rd_pc/rd_instr 0, cycles 0, overflow 0, drop_count 0, busy 0, done 0, result 0, shadows 0, FIFO empty, state IDLE.
- Push-to-rd_valid latency is 1 cycle, with no bypass. An empty FIFO with a same-cycle push shows rd_valid=0 in that cycle.
- Pop-to-next-record latency is 0: rd_* update in the cycle after the accepting edge.
- rd_* are stable while rd_valid && !rd_ready.
- done rises on the first cycle of DONE, one cycle after the FIFO-empty condition.
- Reset asserted mid-RUN or mid-DRAIN clears everything immediately. Queued records are lost.
- All outputs are registered, except rd_* which are FIFO read-port outputs gated by rd_valid.

## Test plan
- **Reset / idle.** Hold rst 3 cycles, then en=0 for 10 cycles. Required: all outputs 0, rd_valid 0, state IDLE.
- **Stamping.** Raise en, then pc=0,4,8 with pc_valid=1 on consecutive cycles and rd_ready=1. Required: records (1,0), (2,4), (3,8), each appearing one cycle after its push.
- **Overflow.** DEPTH=16, rd_ready=0, 20 valid PCs. Required: 16 records kept, overflow=1, drop_count=4. Then push and pop in the same cycle while full; required: drop_count still 4.
- **Halt with pending write.** halt_pc=68, shadow[4]=1, wb writes r4=0 in the same cycle as pc=68. Required: no halt that cycle; halt on the next pc≥68. r5 written as 70 during DRAIN gives result=70 and done=1 after the FIFO drains.
- **Pause and clear.** en=0 for 5 cycles mid-RUN: cycles frozen, no records. Then assert clear in DONE: return to IDLE, all counters and result 0.
- **Async reset mid-DRAIN with 6 queued records.** Required: rd_valid=0 and busy=0 within the same cycle as the rst edge.

Source files
------------

// File: rtl/trace_monitor.sv
`default_nettype none
// ============================================================================
// Module      : trace_monitor
// Description : Pipeline trace and halt monitor for a 5-stage Nios II core.
//               Timestamps fetched PC/instruction pairs into a trace FIFO,
//               shadows two architectural registers from the write-back
//               port, detects program end (PC >= halt_pc with the watched
//               register zero) and latches the result register on halt.
// Ports       : clk, rst (async, active-high)
//               en, clear                      - capture control
//               pc_valid, pc, instr            - fetch-stage snoop
//               wb_en, wb_addr, wb_data        - write-back snoop
//               halt_pc                        - halt address (unsigned)
//               rd_valid/rd_ready, rd_stamp/rd_pc/rd_instr - trace readout
//               cycles, overflow, drop_count, busy, done, result - status
// Revision    : 1.0 - initial release
// ============================================================================
module trace_monitor #(
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 16,
    parameter int CNT_W      = 32,
    parameter int WATCH_REG  = 4,
    parameter int RESULT_REG = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clear,
    input  logic              pc_valid,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] instr,
    input  logic              wb_en,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [DATA_W-1:0] halt_pc,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [CNT_W-1:0]  rd_stamp,
    output logic [DATA_W-1:0] rd_pc,
    output logic [DATA_W-1:0] rd_instr,
    output logic [CNT_W-1:0]  cycles,
    output logic              overflow,
    output logic [7:0]        drop_count,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    localparam int         c_AW         = $clog2(DEPTH);
    localparam int         c_REC_W      = CNT_W + 2 * DATA_W;
    localparam logic [4:0] c_WATCH_IDX  = 5'(WATCH_REG);
    localparam logic [4:0] c_RESULT_IDX = 5'(RESULT_REG);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [c_REC_W-1:0] r_mem [DEPTH];
    logic [c_AW:0]      r_wr_ptr;
    logic [c_AW:0]      r_rd_ptr;
    logic [CNT_W-1:0]   r_cycles;
    logic               r_overflow;
    logic [7:0]         r_drop_count;
    logic               r_busy;
    logic               r_done;
    logic [DATA_W-1:0]  r_result;
    logic [DATA_W-1:0]  r_shadow_watch;
    logic [DATA_W-1:0]  r_shadow_result;

    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_push_req;
    logic               w_push;
    logic               w_drop;
    logic               w_halt;
    logic [CNT_W-1:0]   w_cycles_inc;
    logic [DATA_W-1:0]  w_watch_next;
    logic [DATA_W-1:0]  w_result_next;
    logic [c_REC_W-1:0] w_head;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_pop   = !w_empty && rd_ready;

    // Saturating increment; the stamp uses the same value so it counts the
    // current cycle.
    assign w_cycles_inc = (r_cycles == '1) ? r_cycles : r_cycles + CNT_W'(1);

    assign w_push_req = (r_state == c_ST_RUN) && en && pc_valid;
    // When full, a simultaneous pop frees the head slot, which is exactly the
    // slot the write pointer addresses, so the push can be accepted.
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && w_full && !w_pop;
    // Uses the registered shadow: a same-cycle write-back is not yet visible.
    assign w_halt     = w_push_req && (pc >= halt_pc) && (r_shadow_watch == '0);

    // Shadow register index 0 stays constant zero.
    assign w_watch_next  = (wb_en && (wb_addr == c_WATCH_IDX) && (c_WATCH_IDX != 5'd0))
                           ? wb_data : r_shadow_watch;
    assign w_result_next = (wb_en && (wb_addr == c_RESULT_IDX) && (c_RESULT_IDX != 5'd0))
                           ? wb_data : r_shadow_result;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE:  if (en)      w_state_next = c_ST_RUN;
            c_ST_RUN:   if (w_halt)  w_state_next = c_ST_DRAIN;
            c_ST_DRAIN: if (w_empty) w_state_next = c_ST_DONE;
            default:                 w_state_next = r_state;
        endcase
        if (clear) w_state_next = c_ST_IDLE;
    end

    // Storage array has no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_push && !clear) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= {w_cycles_inc, pc, instr};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= c_ST_IDLE;
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_cycles        <= '0;
            r_overflow      <= 1'b0;
            r_drop_count    <= 8'd0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_result        <= '0;
            r_shadow_watch  <= '0;
            r_shadow_result <= '0;
        end else if (clear) begin
            r_state         <= c_ST_IDLE;
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_cycles        <= '0;
            r_overflow      <= 1'b0;
            r_drop_count    <= 8'd0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_result        <= '0;
            r_shadow_watch  <= '0;
            r_shadow_result <= '0;
        end else begin
            r_state         <= w_state_next;
            r_busy          <= (w_state_next == c_ST_RUN) || (w_state_next == c_ST_DRAIN);
            r_done          <= (w_state_next == c_ST_DONE);
            r_shadow_watch  <= w_watch_next;
            r_shadow_result <= w_result_next;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if ((r_state == c_ST_RUN) && en) r_cycles <= w_cycles_inc;
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != 8'hFF) r_drop_count <= r_drop_count + 8'd1;
            end
            // Result includes any write-back landing in the transition cycle.
            if ((r_state == c_ST_DRAIN) && w_empty) r_result <= w_result_next;
        end
    end

    assign w_head   = r_mem[r_rd_ptr[c_AW-1:0]];
    assign rd_valid = !w_empty;
    assign rd_stamp = rd_valid ? w_head[c_REC_W-1 -: CNT_W]  : '0;
    assign rd_pc    = rd_valid ? w_head[2*DATA_W-1 -: DATA_W] : '0;
    assign rd_instr = rd_valid ? w_head[DATA_W-1:0]           : '0;

    assign cycles     = r_cycles;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;
    assign busy       = r_busy;
    assign done       = r_done;
    assign result     = r_result;

endmodule
`default_nettype wire

// File: tb/tb_trace_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_trace_monitor
// Description : Directed, table-driven bench for trace_monitor: idle after
//               reset, stamping, pause, overflow, halt with pending write,
//               clear from DONE and asynchronous reset during DRAIN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trace_monitor;

    localparam logic [31:0] c_IK = 32'hA5A5_0000;

    logic        clk;
    logic        rst;
    logic        en;
    logic        clear;
    logic        pc_valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] halt_pc;
    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] rd_stamp;
    logic [31:0] rd_pc;
    logic [31:0] rd_instr;
    logic [31:0] cycles;
    logic        overflow;
    logic [7:0]  drop_count;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_checks = 0;
    int n_err    = 0;

    trace_monitor #(
        .DATA_W(32), .DEPTH(16), .CNT_W(32), .WATCH_REG(4), .RESULT_REG(5)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .clear(clear),
        .pc_valid(pc_valid), .pc(pc), .instr(instr),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .halt_pc(halt_pc),
        .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_stamp(rd_stamp), .rd_pc(rd_pc), .rd_instr(rd_instr),
        .cycles(cycles), .overflow(overflow), .drop_count(drop_count),
        .busy(busy), .done(done), .result(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        pv;
        logic [31:0] pc;
        logic        rdy;
        logic        ev;
        logic [31:0] es;
        logic [31:0] ep;
        logic [31:0] ec;
    } vec_t;

    vec_t tbl [13];

    function automatic vec_t mk(logic e, logic v, logic [31:0] p, logic r,
                                logic xv, logic [31:0] xs, logic [31:0] xp,
                                logic [31:0] xc);
        vec_t t;
        t.en = e; t.pv = v; t.pc = p; t.rdy = r;
        t.ev = xv; t.es = xs; t.ep = xp; t.ec = xc;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic v, input logic [31:0] p, input logic r);
        en = e; pc_valid = v; pc = p; instr = p ^ c_IK; rd_ready = r;
    endtask

    task automatic wb(input logic w, input logic [4:0] a, input logic [31:0] d);
        wb_en = w; wb_addr = a; wb_data = d;
    endtask

    initial begin
        int cnt;
        int guard;
        logic [31:0] last_pc;
        logic [31:0] last_stamp;

        rst = 1'b1; clear = 1'b0; halt_pc = 32'hFFFF_0000;
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        wb(1'b0, 5'd0, 32'h0);
        repeat (3) tick();
        rst = 1'b0;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_flags", {60'h0, rd_valid, busy, done, overflow}, 64'h0);
            chk("idle_counts", {cycles, 24'h0, drop_count}, 64'h0);
            if (i == 9) chk("idle_rd", {rd_pc, result}, 64'h0);
        end

        // Stamping and pause
        tbl[0]  = mk(1, 1, 32'h100, 1, 0, 0, 0, 0);
        tbl[1]  = mk(1, 1, 32'd0,   1, 1, 1, 0, 1);
        tbl[2]  = mk(1, 1, 32'd4,   1, 1, 2, 4, 2);
        tbl[3]  = mk(1, 1, 32'd8,   1, 1, 3, 8, 3);
        tbl[4]  = mk(1, 0, 32'd0,   1, 0, 0, 0, 4);
        for (int i = 5; i < 10; i++) tbl[i] = mk(0, 1, 32'd12, 1, 0, 0, 0, 4);
        tbl[10] = mk(1, 1, 32'd12,  0, 1, 5, 12, 5);
        tbl[11] = mk(1, 0, 32'd0,   0, 1, 5, 12, 6);
        tbl[12] = mk(1, 0, 32'd0,   1, 0, 0, 0, 7);

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].en, tbl[i].pv, tbl[i].pc, tbl[i].rdy);
            tick();
            chk($sformatf("vec%0d_valid", i), {63'h0, rd_valid}, {63'h0, tbl[i].ev});
            chk($sformatf("vec%0d_rec", i), {rd_stamp, rd_pc}, {tbl[i].es, tbl[i].ep});
            chk($sformatf("vec%0d_instr", i), {32'h0, rd_instr},
                {32'h0, tbl[i].ev ? (tbl[i].ep ^ c_IK) : 32'h0});
            chk($sformatf("vec%0d_cyc_busy", i), {31'h0, busy, cycles}, {31'h0, 1'b1, tbl[i].ec});
        end

        // Overflow: 20 pushes into 16 entries
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b1, 32'h200 + 32'(4 * i), 1'b0);
            tick();
        end
        chk("ovf_flags", {55'h0, overflow, drop_count}, {55'h0, 1'b1, 8'd4});
        chk("ovf_head", {rd_stamp, rd_pc}, {32'd8, 32'h200});
        chk("ovf_cycles", {32'h0, cycles}, 64'd27);
        // Push with simultaneous pop while full
        drive(1'b1, 1'b1, 32'h300, 1'b1);
        tick();
        chk("full_pushpop_drop", {56'h0, drop_count}, 64'd4);
        chk("full_pushpop_head", {rd_stamp, rd_pc}, {32'd9, 32'h204});
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        cnt = 0; guard = 0; last_pc = 0; last_stamp = 0;
        while (rd_valid && guard < 40) begin
            last_pc = rd_pc; last_stamp = rd_stamp;
            cnt++; guard++;
            tick();
        end
        chk("ovf_drain_count", 64'(cnt), 64'd16);
        chk("ovf_drain_last", {last_stamp, last_pc}, {32'd28, 32'h300});

        // Halt with pending write of the watched register
        halt_pc = 32'd68;
        drive(1'b1, 1'b0, 32'h0, 1'b0); wb(1'b1, 5'd4, 32'd1);
        tick();
        chk("h0_busy", {62'h0, busy, done}, {62'h0, 2'b10});
        drive(1'b1, 1'b1, 32'd68, 1'b0); wb(1'b1, 5'd4, 32'd0);
        tick();
        chk("h1_rec", {rd_stamp, rd_pc}, {32'd30, 32'd68});
        chk("h1_cycles", {32'h0, cycles}, 64'd30);
        drive(1'b1, 1'b1, 32'd72, 1'b0); wb(1'b0, 5'd0, 32'd0);
        tick();
        drive(1'b1, 1'b1, 32'd76, 1'b0); wb(1'b1, 5'd5, 32'd11);
        tick();
        chk("drain_cycles_held", {32'h0, cycles}, 64'd31);
        chk("drain_busy", {62'h0, busy, done}, {62'h0, 2'b10});
        drive(1'b1, 1'b0, 32'h0, 1'b1); wb(1'b0, 5'd0, 32'd0);
        chk("drain_head0", {32'h0, rd_pc}, 64'd68);
        tick();
        chk("drain_head1", {31'h0, rd_valid, rd_pc}, {31'h0, 1'b1, 32'd72});
        tick();
        chk("drain_empty_not_done", {61'h0, rd_valid, busy, done}, {61'h0, 3'b010});
        wb(1'b1, 5'd5, 32'd70);
        tick();
        wb(1'b0, 5'd0, 32'd0);
        chk("done_flags", {62'h0, busy, done}, {62'h0, 2'b01});
        chk("done_result", {32'h0, result}, 64'd70);
        tick();
        chk("done_hold", {31'h0, done, result}, {31'h0, 1'b1, 32'd70});

        // Clear from DONE
        clear = 1'b1;
        tick();
        clear = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        chk("clear_flags", {60'h0, rd_valid, busy, done, overflow}, 64'h0);
        chk("clear_counts", {cycles, 24'h0, drop_count}, 64'h0);
        chk("clear_result", {32'h0, result}, 64'h0);

        // Async reset mid-DRAIN with 6 queued records
        halt_pc = 32'h1000;
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 32'h10 + 32'(4 * i), 1'b0);
            tick();
        end
        drive(1'b1, 1'b1, 32'h1000, 1'b0);
        tick();
        drive(1'b1, 1'b1, 32'h24, 1'b0);
        tick();
        chk("pre_rst_drain", {30'h0, rd_valid, busy, cycles}, {30'h0, 2'b11, 32'd6});
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst", {30'h0, rd_valid, busy, cycles}, 64'h0);
        chk("async_rst_rd", {rd_stamp, rd_pc}, 64'h0);
        tick();
        rst = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
